stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences the 8-digit seven-segment display bank. It turns three switch/button inputs into a run/pause/lap/clear state machine and divides clk down to a seconds tick. It keeps an MM:SS time and a lap counter, and drives one 4-bit code per digit plus a blank mask into the existing per-digit segment decoders. Sits between board switches and the decoder instances in the top level.

---
 rtl/stopwatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM, seconds prescaler, MM:SS time and lap count
// feeding the 8-digit display. Define STOPWATCH_DP_BLINK_EN to add the blinking-separator dp port.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        running,
  output logic        tick
`ifdef STOPWATCH_DP_BLINK_EN
  ,
  output logic [7:0]  dp
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  // Packed so that the 16-bit view lines up directly with digits[15:0].
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd9) r.sec_ones = t.sec_ones + 4'd1;
    else begin
      r.sec_ones = 4'd0;
      if (t.sec_tens != 4'd5) r.sec_tens = t.sec_tens + 4'd1;
      else begin
        r.sec_tens = 4'd0;
        if (t.min_ones != 4'd9) r.min_ones = t.min_ones + 4'd1;
        else begin
          r.min_ones = 4'd0;
          r.min_tens = (t.min_tens == 4'd5) ? 4'd0 : t.min_tens + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Two-digit BCD lap count, saturating at 99.
  function automatic logic [7:0] lap_inc(input logic [7:0] c);
    if (c == 8'h99) return c;
    if (c[3:0] == 4'd9) return {c[7:4] + 4'd1, 4'd0};
    return {c[7:4], c[3:0] + 4'd1};
  endfunction

  logic [2:0] sync1, sync2, prev, rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {clear, lap, start_stop};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  state_t           state, nxt_state;
  bcd_time_t        cur_time, nxt_time, frozen, nxt_frozen;
  logic [7:0]       lap_cnt, nxt_lap;
  logic [DIV_W-1:0] presc, nxt_presc;
  logic             ev_clear, ev_ss, ev_lap, counting, term, lap_zero;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ev_clear   = rise[2];
    ev_ss      = rise[0] & ~rise[2];
    ev_lap     = rise[1] & ~rise[2] & ~rise[0];
    counting   = (state == RUN) || (state == LAP);
    term       = counting && (presc == TERM);
    nxt_state  = state;
    nxt_time   = cur_time;
    nxt_frozen = frozen;
    nxt_lap    = lap_cnt;
    nxt_presc  = presc;

    if (counting) nxt_presc = term ? '0 : presc + DIV_W'(1);
    if (term)     nxt_time  = time_inc(cur_time);

    unique case (state)
      IDLE: if (ev_ss) begin
        nxt_state = RUN;
        nxt_presc = '0;
      end
      RUN: if (ev_ss) nxt_state = PAUSE;
      else if (ev_lap) begin
        nxt_state  = LAP;
        nxt_frozen = nxt_time;
        nxt_lap    = lap_inc(lap_cnt);
      end
      LAP: if (ev_ss) nxt_state = PAUSE;
      else if (ev_lap) nxt_state = RUN;
      PAUSE: if (ev_clear) begin
        nxt_state  = IDLE;
        nxt_time   = '0;
        nxt_frozen = '0;
        nxt_lap    = '0;
        nxt_presc  = '0;
      end else if (ev_ss) nxt_state = RUN;
      default: nxt_state = IDLE;
    endcase

    lap_zero = (nxt_lap == 8'h00);
  end

  // Display outputs are built from next-state values so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur_time <= '0;
      frozen   <= '0;
      lap_cnt  <= '0;
      presc    <= '0;
      tick     <= 1'b0;
      running  <= 1'b0;
      blank    <= 8'hF0;
      digits   <= 32'hFFFF_0000;
    end else begin
      state    <= nxt_state;
      cur_time <= nxt_time;
      frozen   <= nxt_frozen;
      lap_cnt  <= nxt_lap;
      presc    <= nxt_presc;
      tick     <= term;
      running  <= (nxt_state == RUN) || (nxt_state == LAP);
      blank    <= {2'b11, {2{lap_zero}}, 4'b0000};
      digits   <= {8'hFF, lap_zero ? 8'hFF : nxt_lap,
                   (nxt_state == LAP) ? nxt_frozen : nxt_time};
    end
  end

`ifdef STOPWATCH_DP_BLINK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dp <= 8'h00;
    else begin
      dp <= 8'h00;
      if (nxt_state == PAUSE)     dp[2] <= 1'b1;
      else if (nxt_state != IDLE) dp[2] <= term ? ~dp[2] : dp[2];
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=4): directed scenarios plus random pulses, all checked
// against a seconds-count/flag model of the stopwatch rules.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        running, tick;
`ifdef STOPWATCH_DP_BLINK_EN
  logic [7:0]  dp;
`endif

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .digits(digits), .blank(blank), .running(running), .tick(tick)
`ifdef STOPWATCH_DP_BLINK_EN
    , .dp(dp)
`endif
  );

  // Reference model: time as total seconds, mode as flags, input history as raw samples.
  int         m_sec, m_frozen, m_laps, m_presc;
  bit         m_run, m_pause, m_lapview, m_tick;
  logic [2:0] h1, h2, h3;

  task automatic model_reset();
    m_sec = 0; m_frozen = 0; m_laps = 0; m_presc = 0;
    m_run = 0; m_pause = 0; m_lapview = 0; m_tick = 0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  // One clock edge; s = {clear, lap, start_stop} as sampled at this edge.
  task automatic model_edge(input logic [2:0] s);
    logic [2:0] ev;
    bit ev_c, ev_s, ev_l;
    ev = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = s;
    ev_c = ev[2];
    ev_s = ev[0] && !ev_c;
    ev_l = ev[1] && !ev_c && !ev_s;
    m_tick = 0;
    if (m_run) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0; m_tick = 1; m_sec = (m_sec + 1) % 3600;
      end else m_presc++;
    end
    if (!m_run && !m_pause) begin
      if (ev_s) begin m_run = 1; m_presc = 0; end
    end else if (m_pause) begin
      if (ev_c) begin m_pause = 0; m_sec = 0; m_laps = 0; m_presc = 0; end
      else if (ev_s) begin m_pause = 0; m_run = 1; end
    end else if (!m_lapview) begin
      if (ev_s) begin m_run = 0; m_pause = 1; end
      else if (ev_l) begin
        m_lapview = 1; m_frozen = m_sec;
        if (m_laps < 99) m_laps++;
      end
    end else begin
      if (ev_s) begin m_run = 0; m_pause = 1; m_lapview = 0; end
      else if (ev_l) m_lapview = 0;
    end
  endtask

  // Expected {digits, blank, running, tick}.
  function automatic logic [41:0] exp_vec();
    int shown, mm, ss;
    logic [31:0] d;
    logic [7:0]  b;
    shown = m_lapview ? m_frozen : m_sec;
    mm = shown / 60;
    ss = shown % 60;
    d = 32'hFFFF_FFFF;
    d[3:0]   = 4'(ss % 10);
    d[7:4]   = 4'(ss / 10);
    d[11:8]  = 4'(mm % 10);
    d[15:12] = 4'(mm / 10);
    if (m_laps != 0) begin
      d[19:16] = 4'(m_laps % 10);
      d[23:20] = 4'(m_laps / 10);
    end
    b = (m_laps == 0) ? 8'hF0 : 8'hC0;
    return {d, b, m_run, m_tick};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge({clear, lap, start_stop});
    @(negedge clk);
  endtask

  task automatic drive_step(input logic ss, input logic lp, input logic cl);
    start_stop = ss; lap = lp; clear = cl;
    step();
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    if (digits !== 32'hFFFF_0000) begin bad++; $display("FAIL reset_digits: got %h want ffff0000", digits); end
    total++;
    if (blank !== 8'hF0) begin bad++; $display("FAIL reset_blank: got %h want f0", blank); end
    total++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got running=%b tick=%b want 0 0", running, tick);
    end
    total++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_run_ticks();
    int ticks = 0, first_run = -1;
    drive_step(1, 0, 0);
    if (running !== 1'b0) begin bad++; $display("FAIL run_early: got running=%b want 0", running); end
    total++;
    for (int i = 0; i < 60 && ticks < 10; i++) begin
      drive_step(0, 0, 0);
      if ({digits, blank, running, tick} !== exp_vec()) begin
        bad++; $display("FAIL run_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
      if (running === 1'b1 && first_run < 0) first_run = i;
      if (tick === 1'b1) ticks++;
    end
    if (first_run !== 1) begin bad++; $display("FAIL run_latency: got step %0d want 1", first_run); end
    total++;
    if (ticks !== 10) begin bad++; $display("FAIL run_tick_budget: got %0d ticks want 10", ticks); end
    total++;
    if (digits[15:0] !== 16'h0010 || running !== 1'b1) begin
      bad++; $display("FAIL run_10s: got %h running=%b want 0010 running=1", digits[15:0], running);
    end
    total++;
  endtask

  task automatic test_wrap();
    bit seen_carry = 0, seen_wrap = 0;
    for (int i = 0; i < 16000 && !seen_wrap; i++) begin
      step();
      if ({digits, blank, running, tick} !== exp_vec()) begin
        bad++; $display("FAIL wrap_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
      if (m_tick && m_sec == 60) begin
        seen_carry = 1;
        if (digits[15:0] !== 16'h0100) begin bad++; $display("FAIL carry_0100: got %h want 0100", digits[15:0]); end
        total++;
      end
      if (m_tick && m_sec == 0) begin
        seen_wrap = 1;
        if (digits[15:0] !== 16'h0000) begin bad++; $display("FAIL wrap_0000: got %h want 0000", digits[15:0]); end
        total++;
      end
    end
    if (!seen_carry || !seen_wrap) begin
      bad++; $display("FAIL wrap_budget: got carry=%b wrap=%b want 1 1", seen_carry, seen_wrap);
    end
    total++;
  endtask

  task automatic test_lap();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_tick && m_sec == 5) found = 1;
    end
    if (!found) begin bad++; $display("FAIL lap_wait: got no 00:05 tick want one"); end
    total++;
    drive_step(0, 1, 0);
    drive_step(0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step();
      if ({digits, blank, running, tick} !== exp_vec()) begin
        bad++; $display("FAIL lap_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
      if (digits[3:0] !== 4'h5) begin bad++; $display("FAIL lap_frozen: got %h want 5", digits[3:0]); end
      total++;
    end
    if (blank !== 8'hC0 || digits[23:16] !== 8'h01) begin
      bad++; $display("FAIL lap_count: got blank=%h cnt=%h want c0 01", blank, digits[23:16]);
    end
    total++;
    drive_step(0, 1, 0);
    drive_step(0, 0, 0);
    step();
    if ({digits, blank, running, tick} !== exp_vec() || running !== 1'b1) begin
      bad++; $display("FAIL lap_release: got %h want %h", {digits, blank, running, tick}, exp_vec());
    end
    total++;
  endtask

  task automatic test_pause();
    bit found = 0;
    int run_at = -100, tick_at = -100;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (m_presc == 3) found = 1;
    end
    if (!found) begin bad++; $display("FAIL pause_wait: got no prescaler phase 3 want one"); end
    total++;
    drive_step(1, 0, 0);
    drive_step(0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if ({digits, blank, running, tick} !== exp_vec() || tick !== 1'b0 || running !== 1'b0) begin
        bad++; $display("FAIL pause_hold: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
    end
    drive_step(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive_step(0, 0, 0);
      if ({digits, blank, running, tick} !== exp_vec()) begin
        bad++; $display("FAIL resume_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
      if (running === 1'b1 && run_at < 0) run_at = i;
      if (tick === 1'b1 && tick_at < 0) tick_at = i;
    end
    if (tick_at - run_at !== 2) begin
      bad++; $display("FAIL resume_first_tick: got %0d cycles want 2", tick_at - run_at);
    end
    total++;
    drive_step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive_step(0, 0, 0);
      if ({digits, blank, running, tick} !== exp_vec() || running !== 1'b1) begin
        bad++; $display("FAIL clear_in_run: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
    end
  endtask

  task automatic test_clear_priority();
    drive_step(1, 0, 0);
    drive_step(0, 0, 0);
    step();
    drive_step(1, 0, 1);
    drive_step(0, 0, 0);
    step();
    if (digits !== 32'hFFFF_0000 || blank !== 8'hF0 || running !== 1'b0) begin
      bad++; $display("FAIL clear_prio: got d=%h b=%h r=%b want ffff0000 f0 0", digits, blank, running);
    end
    total++;
    if ({digits, blank, running, tick} !== exp_vec()) begin
      bad++; $display("FAIL clear_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
    end
    total++;
  endtask

  task automatic test_lap_saturate();
    drive_step(1, 0, 0);
    drive_step(0, 0, 0);
    step();
    for (int i = 0; i < 220; i++) begin
      drive_step(0, 1, 0);
      if ({digits, blank, running, tick} !== exp_vec()) begin
        bad++; $display("FAIL sat_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
      drive_step(0, 0, 0);
    end
    for (int i = 0; i < 3; i++) step();
    if (digits[23:16] !== 8'h99 || blank !== 8'hC0) begin
      bad++; $display("FAIL lap_sat_99: got cnt=%h blank=%h want 99 c0", digits[23:16], blank);
    end
    total++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int sel, gap;
      sel = int'($urandom_range(0, 3));
      gap = int'($urandom_range(1, 6));
      drive_step(sel == 1, sel == 2, sel == 3);
      for (int g = 0; g <= gap; g++) begin
        if (g > 0) drive_step(0, 0, 0);
        if ({digits, blank, running, tick} !== exp_vec()) begin
          bad++; $display("FAIL rand_vec: got %h want %h", {digits, blank, running, tick}, exp_vec());
        end
        total++;
      end
    end
  endtask

  task automatic test_async_reset();
    if (!m_run) begin
      drive_step(1, 0, 0);
      drive_step(0, 0, 0);
      step();
    end
    for (int i = 0; i < 5; i++) step();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    if (digits !== 32'hFFFF_0000 || blank !== 8'hF0 || running !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: got d=%h b=%h r=%b t=%b want ffff0000 f0 0 0",
                      digits, blank, running, tick);
    end
    total++;
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({digits, blank, running, tick} !== exp_vec() || running !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle: got %h want %h", {digits, blank, running, tick}, exp_vec());
      end
      total++;
    end
    drive_step(1, 0, 0);
    drive_step(0, 0, 0);
    step();
    if (running !== 1'b1) begin bad++; $display("FAIL post_reset_start: got running=%b want 1", running); end
    total++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_ticks();
    test_wrap();
    test_lap();
    test_pause();
    test_clear_priority();
    test_lap_saturate();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
